// File: rtl/sha3_pkg.sv
// Shared Keccak state geometry and lane/state types for the SHA-3 datapath blocks.
package sha3_pkg;

    localparam int ROWS   = 5;
    localparam int COLS   = 5;
    localparam int LANE_W = 64;

    typedef logic [LANE_W-1:0]            lane_t;
    typedef lane_t [ROWS-1:0][COLS-1:0]   state_t;

endpackage

// File: rtl/sha3_state_stage.sv
// One elastic pipe stage: a valid bit plus a full 5x5 state register.
module sha3_state_stage
    import sha3_pkg::*;
#(
    parameter int LANE_W     = 64,
    parameter int CLEAR_DATA = 0
) (
    input  logic                                  clk,
    input  logic                                  clear,
    input  logic                                  load_en,
    input  logic                                  src_valid,
    input  logic [ROWS-1:0][COLS-1:0][LANE_W-1:0] src_data,
    output logic                                  valid,
    output logic [ROWS-1:0][COLS-1:0][LANE_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= 1'b0;
        end else if (load_en) begin
            valid <= src_valid;
        end
    end

    // Data only toggles when a real state arrives, so bubbles cost no switching.
    always_ff @(posedge clk) begin
        if ((CLEAR_DATA != 0) && clear) begin
            data <= '0;
        end else if (!clear && load_en && src_valid) begin
            data <= src_data;
        end
    end

endmodule

// File: rtl/sha3_state_pipe.sv
// Elastic DELAY-stage delay line for Keccak states with bubble-collapsing
// backpressure, synchronous flush and an occupancy count.
module sha3_state_pipe
    import sha3_pkg::*;
#(
    parameter int DELAY      = 4,
    parameter int LANE_W     = 64,
    parameter int CLEAR_DATA = 0,
    localparam int CNT_W     = (DELAY > 0) ? $clog2(DELAY + 1) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  isample,
    output logic                                  iready,
    input  logic [ROWS-1:0][COLS-1:0][LANE_W-1:0] istate,
    output logic                                  ogood,
    input  logic                                  oready,
    output logic [ROWS-1:0][COLS-1:0][LANE_W-1:0] ostate,
    output logic [CNT_W-1:0]                      count
);

    // Handshake: a state moves in when isample & iready, and out when
    // ogood & oready, both sampled on the same rising edge of clk.

    if (DELAY < 0) begin : g_bad_delay
        $error("sha3_state_pipe: DELAY must be >= 0");
    end else if (DELAY == 0) begin : g_passthru
        logic unused_clk;
        assign unused_clk = &{1'b0, clk};
        assign ostate     = istate;
        assign ogood      = isample & ~flush;
        assign iready     = oready & ~flush & ~rst;
        assign count      = '0;
    end else begin : g_pipe
        localparam int L = DELAY - 1;

        logic [DELAY-1:0]                      v;
        logic [DELAY-1:0]                      acc;
        logic [ROWS-1:0][COLS-1:0][LANE_W-1:0] d [DELAY];
        logic                                  clear;
        logic                                  in_xfer;
        logic                                  out_xfer;

        assign clear = rst | flush;

        // A stage may advance if it is empty or everything ahead of it moves.
        assign acc[L] = ~v[L] | oready;
        for (genvar k = 0; k < L; k++) begin : g_acc
            assign acc[k] = ~v[k] | acc[k+1];
        end

        for (genvar k = 0; k < DELAY; k++) begin : g_stage
            if (k == 0) begin : g_head
                sha3_state_stage #(
                    .LANE_W     (LANE_W),
                    .CLEAR_DATA (CLEAR_DATA)
                ) u_stage (
                    .clk       (clk),
                    .clear     (clear),
                    .load_en   (acc[0]),
                    .src_valid (isample),
                    .src_data  (istate),
                    .valid     (v[0]),
                    .data      (d[0])
                );
            end else begin : g_body
                sha3_state_stage #(
                    .LANE_W     (LANE_W),
                    .CLEAR_DATA (CLEAR_DATA)
                ) u_stage (
                    .clk       (clk),
                    .clear     (clear),
                    .load_en   (acc[k]),
                    .src_valid (v[k-1]),
                    .src_data  (d[k-1]),
                    .valid     (v[k]),
                    .data      (d[k])
                );
            end
        end

        assign iready   = acc[0] & ~flush & ~rst;
        assign ogood    = v[L] & ~rst;
        assign ostate   = d[L];
        assign in_xfer  = isample & iready;
        assign out_xfer = ogood & oready;

        always_ff @(posedge clk) begin
            if (clear) begin
                count <= '0;
            end else if (in_xfer && !out_xfer) begin
                count <= count + CNT_W'(1);
            end else if (out_xfer && !in_xfer) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sha3_state_pipe.sv
// Directed checks of the elastic state pipe (DELAY=4) and its DELAY=0 pass-through build.
module tb_sha3_state_pipe;

    localparam int LW = 16;
    typedef logic [4:0][4:0][LW-1:0] st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, isample, iready, ogood, oready;
    st_t        istate, ostate;
    logic [2:0] count;

    logic       z_rst, z_flush, z_isample, z_iready, z_ogood, z_oready;
    st_t        z_istate, z_ostate;
    logic [0:0] z_count;

    int n_cmp  = 0;
    int n_fail = 0;

    sha3_state_pipe #(.DELAY(4), .LANE_W(LW), .CLEAR_DATA(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .isample(isample), .iready(iready),
        .istate(istate), .ogood(ogood), .oready(oready), .ostate(ostate), .count(count)
    );

    sha3_state_pipe #(.DELAY(0), .LANE_W(LW), .CLEAR_DATA(0)) dut_z (
        .clk(clk), .rst(z_rst), .flush(z_flush), .isample(z_isample), .iready(z_iready),
        .istate(z_istate), .ogood(z_ogood), .oready(z_oready), .ostate(z_ostate), .count(z_count)
    );

    function automatic st_t mk(input int tag);
        st_t s;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s[r][c] = {tag[7:0], 4'(r), 4'(c)};
        return s;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; isample = 1'b0; oready = 1'b1; istate = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL rst_ogood got %b want 0", ogood); end
            n_cmp++; if (iready !== 1'b0) begin n_fail++; $display("FAIL rst_iready got %b want 0", iready); end
            next_cycle();
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL rst_ogood_after got %b want 0", ogood); end
        n_cmp++; if (iready !== 1'b1) begin n_fail++; $display("FAIL rst_iready_after got %b want 1", iready); end
        n_cmp++; if (ostate !== st_t'(0)) begin n_fail++; $display("FAIL rst_ostate got %h want 0", ostate); end
        next_cycle();
    endtask

    task automatic test_latency;
        st_t s;
        s = '0;
        s[0][0] = 16'h0001;
        isample = 1'b1; istate = s; oready = 1'b1;
        #1;
        n_cmp++; if (iready !== 1'b1) begin n_fail++; $display("FAIL lat_iready got %b want 1", iready); end
        next_cycle();
        isample = 1'b0; istate = '0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL lat_count cyc=%0d got %0d want 1", i, count); end
            n_cmp++; if (ogood !== (i == 4)) begin n_fail++; $display("FAIL lat_ogood cyc=%0d got %b want %b", i, ogood, (i == 4)); end
            if (i == 4) begin
                n_cmp++; if (ostate !== s) begin n_fail++; $display("FAIL lat_ostate got %h want %h", ostate, s); end
            end
            next_cycle();
        end
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL lat_count_end got %0d want 0", count); end
        n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL lat_ogood_end got %b want 0", ogood); end
        next_cycle();
    endtask

    task automatic test_stream;
        oready = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            isample = (c < 10); istate = mk(c);
            #1;
            n_cmp++; if (iready !== 1'b1) begin n_fail++; $display("FAIL str_iready cyc=%0d got %b want 1", c, iready); end
            if (c >= 4 && c <= 13) begin
                n_cmp++; if (ogood !== 1'b1) begin n_fail++; $display("FAIL str_ogood cyc=%0d got %b want 1", c, ogood); end
                n_cmp++; if (ostate !== mk(c - 4)) begin n_fail++; $display("FAIL str_ostate cyc=%0d got %h want %h", c, ostate, mk(c - 4)); end
            end else begin
                n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL str_ogood cyc=%0d got %b want 0", c, ogood); end
            end
            next_cycle();
        end
        isample = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL str_count_end got %0d want 0", count); end
        next_cycle();
    endtask

    task automatic test_backpressure;
        int exp_cnt;
        oready = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            isample = 1'b1; istate = mk(20 + c);
            exp_cnt = (c < 4) ? c : 4;
            #1;
            n_cmp++; if (iready !== (c < 4)) begin n_fail++; $display("FAIL bp_iready cyc=%0d got %b want %b", c, iready, (c < 4)); end
            n_cmp++; if (count !== 3'(exp_cnt)) begin n_fail++; $display("FAIL bp_count cyc=%0d got %0d want %0d", c, count, exp_cnt); end
            if (c >= 4) begin
                n_cmp++; if (ostate !== mk(20)) begin n_fail++; $display("FAIL bp_hold cyc=%0d got %h want %h", c, ostate, mk(20)); end
            end
            next_cycle();
        end
        oready = 1'b1;
        for (int c = 6; c <= 17; c++) begin
            isample = (c <= 13); istate = mk(20 + c - 2);
            exp_cnt = (c <= 14) ? 4 : 4 - (c - 14);
            #1;
            if (c <= 13) begin
                n_cmp++; if (iready !== 1'b1) begin n_fail++; $display("FAIL bp_iready_rel cyc=%0d got %b want 1", c, iready); end
            end
            n_cmp++; if (ogood !== 1'b1) begin n_fail++; $display("FAIL bp_ogood cyc=%0d got %b want 1", c, ogood); end
            n_cmp++; if (ostate !== mk(20 + c - 6)) begin n_fail++; $display("FAIL bp_order cyc=%0d got %h want %h", c, ostate, mk(20 + c - 6)); end
            n_cmp++; if (count !== 3'(exp_cnt)) begin n_fail++; $display("FAIL bp_count_rel cyc=%0d got %0d want %0d", c, count, exp_cnt); end
            next_cycle();
        end
        isample = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL bp_count_end got %0d want 0", count); end
        n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL bp_ogood_end got %b want 0", ogood); end
        next_cycle();
    endtask

    task automatic test_bubble;
        logic [5:0] pat;
        int tag;
        pat = 6'b111001;
        tag = 40;
        oready = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            isample = pat[c]; istate = mk(tag);
            #1;
            if (pat[c]) begin
                n_cmp++; if (iready !== 1'b1) begin n_fail++; $display("FAIL bub_iready cyc=%0d got %b want 1", c, iready); end
                tag++;
            end
            next_cycle();
        end
        isample = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL bub_count got %0d want 4", count); end
        n_cmp++; if (iready !== 1'b0) begin n_fail++; $display("FAIL bub_iready_full got %b want 0", iready); end
        n_cmp++; if (ostate !== mk(40)) begin n_fail++; $display("FAIL bub_head got %h want %h", ostate, mk(40)); end
        oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (ogood !== 1'b1) begin n_fail++; $display("FAIL bub_ogood i=%0d got %b want 1", i, ogood); end
            n_cmp++; if (ostate !== mk(40 + i)) begin n_fail++; $display("FAIL bub_order i=%0d got %h want %h", i, ostate, mk(40 + i)); end
            next_cycle();
        end
        #1;
        n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL bub_ogood_end got %b want 0", ogood); end
        next_cycle();
    endtask

    task automatic test_flush;
        oready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            isample = 1'b1; istate = mk(50 + c);
            next_cycle();
        end
        flush = 1'b1; isample = 1'b1; istate = mk(99);
        #1;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fl_count_pre got %0d want 3", count); end
        n_cmp++; if (iready !== 1'b0) begin n_fail++; $display("FAIL fl_iready got %b want 0", iready); end
        next_cycle();
        flush = 1'b0; isample = 1'b0; oready = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL fl_count got %0d want 0", count); end
        n_cmp++; if (ostate !== st_t'(0)) begin n_fail++; $display("FAIL fl_ostate got %h want 0", ostate); end
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL fl_ogood i=%0d got %b want 0", i, ogood); end
            next_cycle();
        end
    endtask

    task automatic test_flush_deliver;
        oready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            isample = 1'b1; istate = mk(60 + c);
            next_cycle();
        end
        isample = 1'b0; flush = 1'b1; oready = 1'b1;
        #1;
        n_cmp++; if (ogood !== 1'b1) begin n_fail++; $display("FAIL fd_ogood got %b want 1", ogood); end
        n_cmp++; if (ostate !== mk(60)) begin n_fail++; $display("FAIL fd_ostate got %h want %h", ostate, mk(60)); end
        next_cycle();
        flush = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL fd_count got %0d want 0", count); end
        n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL fd_ogood_after got %b want 0", ogood); end
        next_cycle();
    endtask

    task automatic test_rst_mid;
        oready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            isample = 1'b1; istate = mk(70 + c);
            next_cycle();
        end
        isample = 1'b1; istate = mk(72); rst = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL rm_count_pre got %0d want 2", count); end
        n_cmp++; if (iready !== 1'b0) begin n_fail++; $display("FAIL rm_iready got %b want 0", iready); end
        n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL rm_ogood got %b want 0", ogood); end
        next_cycle();
        rst = 1'b0; isample = 1'b0; oready = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rm_count got %0d want 0", count); end
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++; if (ogood !== 1'b0) begin n_fail++; $display("FAIL rm_ogood i=%0d got %b want 0", i, ogood); end
            next_cycle();
        end
    endtask

    task automatic test_zero_delay;
        // columns: isample, oready, flush, rst, expected ogood, expected iready
        logic [5:0] vec [6];
        vec[0] = 6'b1100_11;
        vec[1] = 6'b0100_01;
        vec[2] = 6'b1000_10;
        vec[3] = 6'b1110_00;
        vec[4] = 6'b1101_10;
        vec[5] = 6'b0001_00;
        for (int i = 0; i < 6; i++) begin
            z_isample = vec[i][5]; z_oready = vec[i][4]; z_flush = vec[i][3]; z_rst = vec[i][2];
            z_istate = mk(80 + i);
            #1;
            n_cmp++; if (z_ostate !== mk(80 + i)) begin n_fail++; $display("FAIL z_ostate v=%0d got %h want %h", i, z_ostate, mk(80 + i)); end
            n_cmp++; if (z_ogood !== vec[i][1]) begin n_fail++; $display("FAIL z_ogood v=%0d got %b want %b", i, z_ogood, vec[i][1]); end
            n_cmp++; if (z_iready !== vec[i][0]) begin n_fail++; $display("FAIL z_iready v=%0d got %b want %b", i, z_iready, vec[i][0]); end
            n_cmp++; if (z_count !== 1'b0) begin n_fail++; $display("FAIL z_count v=%0d got %0d want 0", i, z_count); end
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; isample = 1'b0; oready = 1'b0; istate = '0;
        z_rst = 1'b0; z_flush = 1'b0; z_isample = 1'b0; z_oready = 1'b0; z_istate = '0;
        next_cycle();
        test_reset();
        test_latency();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_flush_deliver();
        test_rst_mid();
        test_zero_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
